interrupt_scheduler: RTL and testbench

Sequences game events into the CPU's interrupt port. Arbitrates frame-rate ticks and debounced jump-key presses into single interrupt instruction words, and holds each one stable until the CPU acknowledges it. It enforces a holdoff gap between interrupts and counts frame ticks lost while a frame interrupt was already pending. It sits between the frame-rate/keyboard logic and `CPU.interrupt_instruction`, in the processor clock domain.

---
 rtl/interrupt_scheduler.sv | 142 ++++++++++++++
 tb/tb_interrupt_scheduler.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : interrupt_scheduler
// Brief   : Arbitrates frame ticks and debounced jump presses into CPU
//           interrupt words, with ack handshake, holdoff and drop counting.
// Rev     : 1.0
// ============================================================================
module interrupt_scheduler #(
  parameter logic [31:0] FRAME_INSN      = 32'h1800_0100,
  parameter logic [31:0] JUMP_INSN       = 32'h1800_0200,
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter int          HOLDOFF_CYCLES  = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        frame_tick,
  input  logic        jump_key,
  input  logic        irq_ack,
  output logic [31:0] interrupt_instruction,
  output logic        irq_valid,
  output logic        pending_frame,
  output logic        pending_jump,
  output logic [7:0]  dropped_frames
);

  localparam int c_DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int c_HO_W  = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
  localparam logic [c_DEB_W-1:0] c_DEB_LAST = c_DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_DEB_W-1:0] c_DEB_ONE  = c_DEB_W'(1);
  localparam logic [c_HO_W-1:0]  c_HO_LOAD  = c_HO_W'(HOLDOFF_CYCLES);
  localparam logic [c_HO_W-1:0]  c_HO_ONE   = c_HO_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_deb_level;
  logic [c_DEB_W-1:0]  r_deb_cnt;
  logic                r_jump_rise;
  logic [c_HO_W-1:0]   r_holdoff;

  logic w_key_differs;
  logic w_deb_flip;
  logic w_grant_jump;
  logic w_grant_frame;

  assign w_key_differs = (jump_key != r_deb_level);
  assign w_deb_flip    = w_key_differs && (r_deb_cnt == c_DEB_LAST);
  assign w_grant_jump  = (r_state == ST_IDLE) && enable && pending_jump;
  assign w_grant_frame = (r_state == ST_IDLE) && enable && pending_frame && !pending_jump;

  // Debouncer; the press event is registered so pending_jump follows the
  // debounced level by one cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_deb_level <= 1'b0;
      r_deb_cnt   <= '0;
      r_jump_rise <= 1'b0;
    end else begin
      r_jump_rise <= w_deb_flip && jump_key;
      if (w_deb_flip) begin
        r_deb_level <= jump_key;
        r_deb_cnt   <= '0;
      end else if (w_key_differs) begin
        r_deb_cnt   <= r_deb_cnt + c_DEB_ONE;
      end else begin
        r_deb_cnt   <= '0;
      end
    end
  end

  // A new request on the same edge as its grant wins, so the flag stays set.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending_frame  <= 1'b0;
      pending_jump   <= 1'b0;
      dropped_frames <= 8'd0;
    end else begin
      if (r_jump_rise) begin
        pending_jump <= 1'b1;
      end else if (w_grant_jump) begin
        pending_jump <= 1'b0;
      end

      if (frame_tick) begin
        pending_frame <= 1'b1;
      end else if (w_grant_frame) begin
        pending_frame <= 1'b0;
      end

      if (frame_tick && pending_frame && !w_grant_frame && (dropped_frames != 8'hFF)) begin
        dropped_frames <= dropped_frames + 8'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state               <= ST_IDLE;
      irq_valid             <= 1'b0;
      interrupt_instruction <= 32'd0;
      r_holdoff             <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_jump) begin
            interrupt_instruction <= JUMP_INSN;
            irq_valid             <= 1'b1;
            r_state               <= ST_ISSUE;
          end else if (w_grant_frame) begin
            interrupt_instruction <= FRAME_INSN;
            irq_valid             <= 1'b1;
            r_state               <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (irq_ack) begin
            interrupt_instruction <= 32'd0;
            irq_valid             <= 1'b0;
            r_holdoff             <= c_HO_LOAD;
            r_state               <= (HOLDOFF_CYCLES == 0) ? ST_IDLE : ST_HOLDOFF;
          end
        end
        ST_HOLDOFF: begin
          r_holdoff <= r_holdoff - c_HO_ONE;
          if (r_holdoff == c_HO_ONE) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_interrupt_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_interrupt_scheduler
// Brief   : Directed scoreboard bench for interrupt_scheduler.
// Rev     : 1.0
// ============================================================================
module tb_interrupt_scheduler;

  localparam logic [31:0] c_FRAME = 32'h1800_0100;
  localparam logic [31:0] c_JUMP  = 32'h1800_0200;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        frame_tick;
  logic        jump_key;
  logic        irq_ack;
  logic [31:0] interrupt_instruction;
  logic        irq_valid;
  logic        pending_frame;
  logic        pending_jump;
  logic [7:0]  dropped_frames;

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] sb[$];
  int          m_drop;
  bit          m_pend;
  int          cnt;

  always #5 clock = ~clock;

  interrupt_scheduler #(
    .FRAME_INSN      (c_FRAME),
    .JUMP_INSN       (c_JUMP),
    .DEBOUNCE_CYCLES (16),
    .HOLDOFF_CYCLES  (4)
  ) dut (
    .clock                 (clock),
    .reset                 (reset),
    .enable                (enable),
    .frame_tick            (frame_tick),
    .jump_key              (jump_key),
    .irq_ack               (irq_ack),
    .interrupt_instruction (interrupt_instruction),
    .irq_valid             (irq_valid),
    .pending_frame         (pending_frame),
    .pending_jump          (pending_jump),
    .dropped_frames        (dropped_frames)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expect irq_valid to rise exactly n edges from now with the next queued word.
  task automatic wait_issue(input string tag, input int n);
    logic [31:0] exp;
    int early;
    early = 0;
    for (int i = 0; i < n - 1; i++) begin
      tick();
      if (irq_valid) early++;
    end
    tick();
    check({tag, " early"}, early, 0);
    check({tag, " valid"}, {31'd0, irq_valid}, 1);
    if (sb.size() == 0) begin
      n_vec++;
      n_miss++;
      $error("FAIL %s: observed issue %0h expected no queued entry", tag, interrupt_instruction);
    end else begin
      exp = sb.pop_front();
      check({tag, " insn"}, interrupt_instruction, exp);
    end
  endtask

  task automatic ack(input string tag);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check({tag, " ack valid"}, {31'd0, irq_valid}, 0);
    check({tag, " ack insn"}, interrupt_instruction, 0);
  endtask

  task automatic idle_count(input int n, output int seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (irq_valid) seen++;
    end
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; frame_tick = 1'b0; jump_key = 1'b0; irq_ack = 1'b0;
    #2;
    check("rst valid", {31'd0, irq_valid}, 0);
    check("rst insn", interrupt_instruction, 0);
    check("rst pend_f", {31'd0, pending_frame}, 0);
    check("rst pend_j", {31'd0, pending_jump}, 0);
    check("rst drop", {24'd0, dropped_frames}, 0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (3) tick();

    // Single frame tick with delayed ack
    frame_tick = 1'b1; tick(); frame_tick = 1'b0;
    check("frame pend", {31'd0, pending_frame}, 1);
    check("frame not yet", {31'd0, irq_valid}, 0);
    sb.push_back(c_FRAME);
    wait_issue("frame", 1);
    check("frame pend clr", {31'd0, pending_frame}, 0);
    repeat (2) tick();
    check("frame hold", interrupt_instruction, c_FRAME);
    ack("frame");
    check("frame drop", {24'd0, dropped_frames}, 0);
    repeat (6) tick();

    // Short press rejected
    jump_key = 1'b1; repeat (15) tick(); jump_key = 1'b0;
    idle_count(20, cnt);
    check("short press", cnt, 0);
    check("short pend_j", {31'd0, pending_jump}, 0);

    // Full press: one interrupt, no repeats while held
    jump_key = 1'b1; repeat (16) tick();
    check("jump pend early", {31'd0, pending_jump}, 0);
    tick();
    check("jump pend", {31'd0, pending_jump}, 1);
    check("jump not yet", {31'd0, irq_valid}, 0);
    sb.push_back(c_JUMP);
    wait_issue("jump", 1);
    ack("jump");
    idle_count(40, cnt);
    check("jump no repeat", cnt, 0);
    jump_key = 1'b0;
    idle_count(20, cnt);
    check("release silent", cnt, 0);

    // Frame and jump pending on the same edge
    jump_key = 1'b1; repeat (16) tick();
    frame_tick = 1'b1; tick(); frame_tick = 1'b0;
    check("sim pend_j", {31'd0, pending_jump}, 1);
    check("sim pend_f", {31'd0, pending_frame}, 1);
    sb.push_back(c_JUMP); sb.push_back(c_FRAME);
    wait_issue("sim jump", 1);
    check("sim frame waits", {31'd0, pending_frame}, 1);
    ack("sim jump");
    wait_issue("sim frame", 5);
    check("sim drop", {24'd0, dropped_frames}, 0);
    ack("sim frame");
    jump_key = 1'b0;
    repeat (25) tick();

    // Ack withheld while ticks keep arriving
    frame_tick = 1'b1; tick(); frame_tick = 1'b0;
    sb.push_back(c_FRAME);
    wait_issue("drop grant", 1);
    m_pend = 1'b0; m_drop = 0;
    for (int i = 0; i < 30; i++) begin
      frame_tick = 1'b1; tick(); frame_tick = 1'b0;
      if (m_pend) m_drop = (m_drop == 255) ? 255 : m_drop + 1;
      else m_pend = 1'b1;
      repeat (9) tick();
    end
    check("drop stable", interrupt_instruction, c_FRAME);
    check("drop valid", {31'd0, irq_valid}, 1);
    check("drop pend_f", {31'd0, pending_frame}, 1);
    check("drop count", {24'd0, dropped_frames}, m_drop);
    check("drop count 29", {24'd0, dropped_frames}, 29);
    for (int i = 0; i < 300; i++) begin
      frame_tick = 1'b1; tick(); frame_tick = 1'b0;
      if (m_pend) m_drop = (m_drop == 255) ? 255 : m_drop + 1;
      else m_pend = 1'b1;
      tick();
    end
    check("drop sat", {24'd0, dropped_frames}, m_drop);
    check("drop stable2", interrupt_instruction, c_FRAME);
    ack("drop");
    sb.push_back(c_FRAME);
    wait_issue("drop release", 5);
    ack("drop release");
    repeat (6) tick();

    // Enable gating
    enable = 1'b0;
    jump_key = 1'b1; repeat (16) tick();
    frame_tick = 1'b1; tick(); frame_tick = 1'b0;
    idle_count(5, cnt);
    check("en blocked", cnt, 0);
    check("en pend_j", {31'd0, pending_jump}, 1);
    check("en pend_f", {31'd0, pending_frame}, 1);
    enable = 1'b1;
    sb.push_back(c_JUMP); sb.push_back(c_FRAME);
    wait_issue("en jump", 1);
    ack("en jump");
    wait_issue("en frame", 5);
    ack("en frame");
    jump_key = 1'b0;
    repeat (25) tick();

    // Asynchronous reset in the middle of an issue
    frame_tick = 1'b1; tick(); frame_tick = 1'b0;
    sb.push_back(c_FRAME);
    wait_issue("pre reset", 1);
    #3 reset = 1'b0;
    #1;
    check("async valid", {31'd0, irq_valid}, 0);
    check("async insn", interrupt_instruction, 0);
    check("async drop", {24'd0, dropped_frames}, 0);
    check("async pend_f", {31'd0, pending_frame}, 0);
    #2 reset = 1'b1;
    idle_count(20, cnt);
    check("post reset quiet", cnt, 0);
    check("sb drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
